// File: rtl/cordic_pkg.sv
// Shared types and default sizing for the CORDIC iteration controller.
`default_nettype none

package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } cordic_state_t;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } cordic_mode_t;

  localparam int CORDIC_NITER = 16;
  localparam int CORDIC_SHW   = 4;

endpackage

`default_nettype wire

// File: rtl/cordic_iter_counter.sv
//------------------------------------------------------------------------------
// cordic_iter_counter : iteration index counter, wraps to 0 after NITER-1.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_iter_counter
  import cordic_pkg::*;
#(
  parameter int NITER = CORDIC_NITER,
  parameter int SHW   = CORDIC_SHW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [SHW-1:0] count_o,
  output logic           last_o
);

  localparam logic [SHW-1:0] LAST = SHW'(NITER - 1);

  logic [SHW-1:0] count_q;
  logic [SHW-1:0] count_d;

  assign last_o  = (count_q == LAST);
  assign count_o = count_q;

  // Wrapping at the last index keeps the counter at 0 when the op finishes.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_iter_ctrl.sv
//------------------------------------------------------------------------------
// cordic_iter_ctrl : CORDIC load/iterate/done sequencer with rotation direction.
// Optional iteration stall port enabled by macro CORDIC_CTRL_HOLD_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int NITER = CORDIC_NITER,
  parameter int SHW   = CORDIC_SHW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic           sign_z_i,
  input  logic           sign_y_i,
`ifdef CORDIC_CTRL_HOLD_EN
  input  logic           hold_i,
`endif
  output logic           ready_o,
  output logic           ld_init_o,
  output logic           iter_en_o,
  output logic [SHW-1:0] sh_o,
  output logic [SHW-1:0] rom_addr_o,
  output logic           dir_o,
  output logic           done_o
);

  cordic_state_t  state_q;
  cordic_mode_t   mode_q;
  logic [SHW-1:0] count;
  logic           last;
  logic           hold;
  logic           advance;

`ifdef CORDIC_CTRL_HOLD_EN
  assign hold = hold_i;
`else
  assign hold = 1'b0;
`endif

  assign advance = (state_q == ITER) && !hold;

  cordic_iter_counter #(
    .NITER (NITER),
    .SHW   (SHW)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == LOAD),
    .en_i    (advance),
    .count_o (count),
    .last_o  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ROTATE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            mode_q  <= cordic_mode_t'(mode_i);
          end
        end
        LOAD:    state_q <= ITER;
        ITER:    if (advance && last) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign ld_init_o  = (state_q == LOAD);
  assign done_o     = (state_q == DONE);
  assign iter_en_o  = advance;
  assign sh_o       = (state_q == ITER) ? count : '0;
  assign rom_addr_o = sh_o;

  // Rotation steers z toward 0, vectoring steers y toward 0.
  assign dir_o = iter_en_o & ((mode_q == VECTOR) ? sign_y_i : ~sign_z_i);

endmodule

`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
// Directed self-checking bench for cordic_iter_ctrl (NITER=16, SHW=4).
`default_nettype none

module tb_cordic_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       sign_z;
  logic       sign_y;
  logic       hold;
  logic       ready;
  logic       ld_init;
  logic       iter_en;
  logic [3:0] sh;
  logic [3:0] rom_addr;
  logic       dir;
  logic       done;

  int checks   = 0;
  int failures = 0;

  localparam logic [12:0] V_IDLE = 13'b1_0_0_0000_0000_0_0;
  localparam logic [12:0] V_LOAD = 13'b0_1_0_0000_0000_0_0;
  localparam logic [12:0] V_DONE = 13'b0_0_0_0000_0000_0_1;

  logic [12:0] obs;
  assign obs = {ready, ld_init, iter_en, sh, rom_addr, dir, done};

  always #5 clk = ~clk;

  cordic_iter_ctrl #(
    .NITER (16),
    .SHW   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .sign_z_i   (sign_z),
    .sign_y_i   (sign_y),
`ifdef CORDIC_CTRL_HOLD_EN
    .hold_i     (hold),
`endif
    .ready_o    (ready),
    .ld_init_o  (ld_init),
    .iter_en_o  (iter_en),
    .sh_o       (sh),
    .rom_addr_o (rom_addr),
    .dir_o      (dir),
    .done_o     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; sign_z = 1'b0; sign_y = 1'b0; hold = 1'b0;
    #2;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs, V_IDLE);
    end
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (obs !== V_IDLE) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs, V_IDLE);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] k4;
    mode = 1'b0; sign_z = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_LOAD) begin
      failures++;
      $display("FAIL lat_load got=%b exp=%b", obs, V_LOAD);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      k4 = 4'(k);
      checks++;
      if (obs !== {3'b001, k4, k4, 2'b10}) begin
        failures++;
        $display("FAIL lat_iter k=%0d got=%b exp=%b", k, obs, {3'b001, k4, k4, 2'b10});
      end
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL lat_done got=%b exp=%b", obs, V_DONE);
    end
    step();
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL lat_ready got=%b exp=%b", obs, V_IDLE);
    end
  endtask

  task automatic test_dir_rotate();
    logic b;
    mode = 1'b0; sign_z = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (dir !== 1'b0) begin
      failures++;
      $display("FAIL rot_dir_load got=%b exp=0", dir);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      b = (k % 2) == 1;
      sign_z = b;
      #1;
      checks++;
      if ({iter_en, dir} !== {1'b1, ~b}) begin
        failures++;
        $display("FAIL rot_dir k=%0d got=%b exp=%b", k, {iter_en, dir}, {1'b1, ~b});
      end
    end
    sign_z = 1'b0;
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL rot_done got=%b exp=%b", obs, V_DONE);
    end
    step();
  endtask

  task automatic test_dir_vector();
    logic [3:0] k4;
    logic       e;
    mode = 1'b1; sign_y = 1'b1; sign_z = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    mode = 1'b0;
    sign_z = 1'b1;
    #1;
    checks++;
    if (obs !== V_LOAD) begin
      failures++;
      $display("FAIL vec_load got=%b exp=%b", obs, V_LOAD);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      sign_y = (k != 8);
      e = (k != 8);
      k4 = 4'(k);
      #1;
      checks++;
      if (obs !== {3'b001, k4, k4, e, 1'b0}) begin
        failures++;
        $display("FAIL vec_iter k=%0d got=%b exp=%b", k, obs, {3'b001, k4, k4, e, 1'b0});
      end
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL vec_done got=%b exp=%b", obs, V_DONE);
    end
    sign_y = 1'b0; sign_z = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] k4;
    mode = 1'b0; sign_z = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k >= 5) start = 1'b1;
      k4 = 4'(k);
      checks++;
      if (obs !== {3'b001, k4, k4, 2'b10}) begin
        failures++;
        $display("FAIL b2b_iter k=%0d got=%b exp=%b", k, obs, {3'b001, k4, k4, 2'b10});
      end
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=%b", obs, V_DONE);
    end
    step();
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=%b", obs, V_IDLE);
    end
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_LOAD) begin
      failures++;
      $display("FAIL b2b_load2 got=%b exp=%b", obs, V_LOAD);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      k4 = 4'(k);
      checks++;
      if (obs !== {3'b001, k4, k4, 2'b10}) begin
        failures++;
        $display("FAIL b2b_iter2 k=%0d got=%b exp=%b", k, obs, {3'b001, k4, k4, 2'b10});
      end
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL b2b_done2 got=%b exp=%b", obs, V_DONE);
    end
    step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (obs !== {3'b001, 4'd7, 4'd7, 2'b10}) begin
      failures++;
      $display("FAIL rmid_at7 got=%b exp=%b", obs, {3'b001, 4'd7, 4'd7, 2'b10});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL rmid_async got=%b exp=%b", obs, V_IDLE);
    end
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (obs !== V_IDLE) begin
        failures++;
        $display("FAIL rmid_nodone cyc=%0d got=%b exp=%b", c, obs, V_IDLE);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs !== V_LOAD) begin
      failures++;
      $display("FAIL rmid_load got=%b exp=%b", obs, V_LOAD);
    end
    step();
    checks++;
    if (obs !== {3'b001, 4'd0, 4'd0, 2'b10}) begin
      failures++;
      $display("FAIL rmid_sh0 got=%b exp=%b", obs, {3'b001, 4'd0, 4'd0, 2'b10});
    end
    for (int k = 1; k < 16; k++) step();
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL rmid_done got=%b exp=%b", obs, V_DONE);
    end
    step();
  endtask

`ifdef CORDIC_CTRL_HOLD_EN
  task automatic test_hold();
    logic [3:0] k4;
    mode = 1'b0; sign_z = 1'b0; hold = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int h = 0; h < 3; h++) begin
      step();
      hold = 1'b1;
      #1;
      checks++;
      if (obs !== {3'b000, 4'd4, 4'd4, 2'b00}) begin
        failures++;
        $display("FAIL hold_frozen h=%0d got=%b exp=%b", h, obs, {3'b000, 4'd4, 4'd4, 2'b00});
      end
    end
    step();
    hold = 1'b0;
    #1;
    checks++;
    if (obs !== {3'b001, 4'd4, 4'd4, 2'b10}) begin
      failures++;
      $display("FAIL hold_release got=%b exp=%b", obs, {3'b001, 4'd4, 4'd4, 2'b10});
    end
    for (int k = 5; k < 16; k++) begin
      step();
      k4 = 4'(k);
      checks++;
      if (obs !== {3'b001, k4, k4, 2'b10}) begin
        failures++;
        $display("FAIL hold_iter k=%0d got=%b exp=%b", k, obs, {3'b001, k4, k4, 2'b10});
      end
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL hold_done got=%b exp=%b", obs, V_DONE);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_dir_rotate();
    test_dir_vector();
    test_back_to_back();
    test_reset_mid();
`ifdef CORDIC_CTRL_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
